ble_aa_correlator: RTL and testbench

- Downstream of the BLE timing-recovery stage; consumes raw 4-bit I/Q at 16 MHz plus its once-per-bit `update_data` strobe.
- Per strobe: makes a GFSK hard-bit decision with a one-sample differential phase discriminator.
- Shifts decided bits into a 32-bit window and declares packet start when the window matches the programmed access address within an error budget.
- Then streams a fixed number of payload bits to the packet/CRC stage and re-arms.

---
 rtl/ble_aa_correlator.sv | 183 ++++++++++++++++++
 tb/tb_ble_aa_correlator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_aa_correlator.sv
// ble_aa_correlator
//   BLE access-address correlator. Sits behind timing recovery: every
//   update_data strobe it makes a GFSK hard-bit decision with a one-sample
//   differential phase discriminator. Decided bits are shifted into an
//   AA_WIDTH-bit window. When the window matches access_addr within max_err
//   bit errors, packet start is flagged and the next PKT_BITS decided bits
//   are streamed to the packet/CRC stage before the block re-arms.
//
// Ports
//   clk            16 MHz sample clock
//   rst            synchronous active-low reset
//   en             block enable; low forces SEARCH and clears the window
//   I_in, Q_in     signed 4-bit I/Q samples, one per clk
//   update_data    one-clk bit strobe from timing recovery
//   access_addr    expected access address, bit 0 first on air
//   max_err        allowed Hamming distance (0..7)
//   bit_out        payload bit
//   bit_valid      one-clk qualifier for bit_out
//   packet_detect  one-clk pulse on access-address match
//   packet_done    one-clk pulse alongside the last payload bit_valid
//   in_packet      high while streaming payload
module ble_aa_correlator #(
  parameter int AA_WIDTH = 32,
  parameter int PKT_BITS = 336,
  parameter int CNT_W    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [3:0]   I_in,
  input  logic signed [3:0]   Q_in,
  input  logic                update_data,
  input  logic [AA_WIDTH-1:0] access_addr,
  input  logic [2:0]          max_err,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                packet_detect,
  output logic                packet_done,
  output logic                in_packet
);

  localparam int FILL_W = $clog2(AA_WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(AA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PKT_BITS - 1);

  typedef enum logic {SEARCH = 1'b0, PAYLOAD = 1'b1} state_t;

  // 4x4 signed multiply with both operands explicitly sign-extended to 8 bits.
  // The true product lies in -56..+64, so the 8-bit result never wraps.
  function automatic logic signed [7:0] smul4(input logic signed [3:0] a,
                                              input logic signed [3:0] b);
    logic signed [7:0] a8;
    logic signed [7:0] b8;
    a8 = {{4{a[3]}}, a};
    b8 = {{4{b[3]}}, b};
    return a8 * b8;
  endfunction

  function automatic logic [FILL_W-1:0] popcount(input logic [AA_WIDTH-1:0] v);
    logic [FILL_W-1:0] n;
    n = '0;
    for (int k = 0; k < AA_WIDTH; k++) begin
      n = n + FILL_W'(v[k]);
    end
    return n;
  endfunction

  state_t                state_q, state_d;
  logic signed [3:0]     i_dly_q, q_dly_q;
  logic [AA_WIDTH-1:0]   win_q;
  logic [FILL_W-1:0]     fill_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  bit_out_q, bit_valid_q, detect_q, done_q;

  logic signed [7:0]     prod_a, prod_b;
  logic signed [8:0]     disc;
  logic                  dec_bit;
  logic                  match;
  logic                  pay_strobe;
  logic                  shift_en;
  logic                  last_bit;
  logic [CNT_W-1:0]      cnt_base;

  // Discriminator: sign of the cross product of consecutive samples, i.e. the
  // direction of phase rotation. Zero rotation decides 0.
  always_comb begin
    prod_a  = smul4(i_dly_q, Q_in);
    prod_b  = smul4(q_dly_q, I_in);
    disc    = {prod_a[7], prod_a} - {prod_b[7], prod_b};
    dec_bit = !disc[8] && (disc != 9'sd0);
  end

  // Match is evaluated on the registered window, so it fires the cycle after
  // the shift that completed it. A strobe landing in that same cycle is
  // already the first payload bit (counter restarts from zero).
  always_comb begin
    match      = en && (state_q == SEARCH) && (fill_q == FILL_FULL) &&
                 (popcount(win_q ^ access_addr) <= FILL_W'(max_err));
    pay_strobe = en && update_data && ((state_q == PAYLOAD) || match);
    shift_en   = en && update_data && (state_q == SEARCH) && !match;
    cnt_base   = match ? '0 : cnt_q;
    last_bit   = pay_strobe && (cnt_base == LAST_CNT);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = SEARCH;
    end else begin
      case (state_q)
        SEARCH:  if (match)    state_d = last_bit ? SEARCH : PAYLOAD;
        PAYLOAD: if (last_bit) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_packet = (state_q == PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_dly_q     <= '0;
      q_dly_q     <= '0;
      win_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      detect_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Sample delay line runs regardless of enable.
      i_dly_q     <= I_in;
      q_dly_q     <= Q_in;
      bit_valid_q <= 1'b0;
      detect_q    <= 1'b0;
      done_q      <= 1'b0;
      if (!en) begin
        win_q  <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
      end else begin
        detect_q <= match;
        if (shift_en) begin
          win_q <= {dec_bit, win_q[AA_WIDTH-1:1]};
          if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
        end
        if (match) cnt_q <= '0;
        if (pay_strobe) begin
          bit_out_q   <= dec_bit;
          bit_valid_q <= 1'b1;
          cnt_q       <= cnt_base + CNT_W'(1);
          // Leaving PAYLOAD: a new access address needs a completely fresh fill.
          if (last_bit) begin
            done_q <= 1'b1;
            cnt_q  <= '0;
            win_q  <= '0;
            fill_q <= '0;
          end
        end
      end
    end
  end

  assign bit_out       = bit_out_q;
  assign bit_valid     = bit_valid_q;
  assign packet_detect = detect_q;
  assign packet_done   = done_q;

endmodule

// File: tb/tb_ble_aa_correlator.sv
module tb_ble_aa_correlator;

  localparam int PKT_BITS = 336;
  localparam logic signed [3:0] P7 = 4'sd7;
  localparam logic signed [3:0] N7 = -4'sd7;
  localparam logic signed [3:0] N8 = 4'sb1000;
  localparam logic signed [3:0] Z0 = 4'sd0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic signed [3:0] I_in = P7;
  logic signed [3:0] Q_in = Z0;
  logic              update_data = 1'b0;
  logic [31:0]       access_addr = 32'h8E89BED6;
  logic [2:0]        max_err = 3'd0;
  logic              bit_out, bit_valid, packet_detect, packet_done, in_packet;

  ble_aa_correlator #(.AA_WIDTH(32), .PKT_BITS(PKT_BITS), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .en(en), .I_in(I_in), .Q_in(Q_in),
    .update_data(update_data), .access_addr(access_addr), .max_err(max_err),
    .bit_out(bit_out), .bit_valid(bit_valid), .packet_detect(packet_detect),
    .packet_done(packet_done), .in_packet(in_packet)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic b;
    logic last;
    int   cyc;
  } item_t;

  item_t exp_q[$];
  int    det_q[$];
  item_t mon_it;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_valid = 0;
  int    n_done = 0;
  int    n_det = 0;

  // reference model state
  logic [31:0] m_win;
  int          m_fill;
  bit          m_pkt;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int k = 0; k < 32; k++) n += int'(v[k]);
    return n;
  endfunction

  task automatic model_clear();
    m_win = '0; m_fill = 0; m_pkt = 0; m_cnt = 0;
  endtask

  // Called in the cycle a strobe is driven (cyc = strobe cycle).
  task automatic model_strobe(input logic b);
    item_t it;
    if (!m_pkt) begin
      m_win = {b, m_win[31:1]};
      if (m_fill < 32) m_fill++;
      if (m_fill == 32 && popc(m_win ^ access_addr) <= int'(max_err)) begin
        det_q.push_back(cyc + 2);
        m_pkt = 1;
        m_cnt = 0;
      end
    end else begin
      it.b = b;
      it.last = (m_cnt == PKT_BITS - 1);
      it.cyc = cyc + 1;
      exp_q.push_back(it);
      m_cnt++;
      if (it.last) model_clear();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      I_in = P7; Q_in = Z0; update_data = 1'b0;
    end
  endtask

  // 16-clk bit period: 14 idle samples, a chosen previous sample, then the
  // strobe sample. The expected decision is supplied by the caller.
  task automatic strobe(input logic signed [3:0] ip, input logic signed [3:0] qp,
                        input logic signed [3:0] ic, input logic signed [3:0] qc,
                        input logic b);
    idle(14);
    tick(); I_in = ip; Q_in = qp; update_data = 1'b0;
    tick(); I_in = ic; Q_in = qc; update_data = 1'b1;
    model_strobe(b);
  endtask

  task automatic send_bit(input logic b);
    strobe(P7, Z0, Z0, b ? P7 : N7, b);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (det_q.size() > 0 && det_q[0] < cyc) begin
      chk("detect_missing", cyc, det_q[0]);
      void'(det_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("bit_missing", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (packet_detect) begin
      n_det++;
      if (det_q.size() == 0) chk("unexp_detect", packet_detect, 1'b0);
      else chk("detect_cyc", cyc, det_q.pop_front());
    end
    if (bit_valid) begin
      n_valid++;
      if (exp_q.size() == 0) chk("unexp_bit", bit_valid, 1'b0);
      else begin
        mon_it = exp_q.pop_front();
        chk("bit_cyc", cyc, mon_it.cyc);
        chk("bit_out", bit_out, mon_it.b);
        chk("done_with_bit", packet_done, mon_it.last);
      end
    end else if (packet_done) begin
      chk("done_no_valid", packet_done, bit_valid);
    end
    if (packet_done) n_done++;
  end

  logic [31:0] aa;
  logic [31:0] aa_flip;
  int          v0, d0, det0, pre;

  initial begin
    aa = 32'h8E89BED6;
    aa_flip = aa ^ 32'h0002_0008;
    model_clear();

    // reset state
    idle(4);
    chk("rst_bit_out", bit_out, 1'b0);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_detect", packet_detect, 1'b0);
    chk("rst_done", packet_done, 1'b0);
    chk("rst_in_packet", in_packet, 1'b0);
    rst = 1'b1; en = 1'b1;
    idle(2);

    // 31 bits after reset must not match; the 32nd completes the AA
    send_word(aa, 31);
    idle(3);
    chk("no_early_detect", n_det, 0);
    chk("in_packet_31", in_packet, 1'b0);
    send_bit(aa[31]);
    idle(2);
    chk("detect_pulse", packet_detect, 1'b1);
    chk("in_packet_hi", in_packet, 1'b1);
    idle(1);
    chk("detect_one_clk", packet_detect, 1'b0);
    v0 = n_valid; d0 = n_done;
    // discriminator corner cases as the first payload bits
    strobe(P7, Z0, P7, Z0, 1'b0);   // static phase, d = 0
    strobe(P7, Z0, Z0, P7, 1'b1);   // +90 deg, d = +49
    strobe(Z0, P7, N7, Z0, 1'b1);   // +90 deg, d = +49
    strobe(N8, N8, P7, N8, 1'b1);   // d = 64 + 56 = +120
    strobe(N8, N8, N8, N8, 1'b0);   // d = 64 - 64 = 0
    strobe(P7, N8, N8, N8, 1'b0);   // d = -56 - 64 = -120
    strobe(N8, P7, N8, N8, 1'b1);   // d = 64 + 56 = +120
    send_random(PKT_BITS - 7);
    idle(2);
    chk("in_packet_after", in_packet, 1'b0);
    chk("valid_count_a", n_valid - v0, PKT_BITS);
    chk("done_count_a", n_done - d0, 1);

    // random prefix, AA, live AA change during payload has no effect
    pre = $urandom_range(0, 31);
    send_random(pre);
    det0 = n_det;
    send_word(aa, 32);
    idle(3);
    chk("detect_prefix", n_det - det0, 1);
    v0 = n_valid;
    send_random(200);
    access_addr = ~aa; max_err = 3'd7;
    send_random(PKT_BITS - 200);
    idle(2);
    chk("valid_count_b", n_valid - v0, PKT_BITS);
    chk("in_packet_b", in_packet, 1'b0);
    access_addr = aa; max_err = 3'd0;

    // two bit errors, budget 2: detect, then abort with en=0 at bit 100
    max_err = 3'd2;
    det0 = n_det;
    send_word(aa_flip, 32);
    idle(3);
    chk("detect_err2", n_det - det0, 1);
    d0 = n_done;
    send_random(100);
    tick(); I_in = P7; Q_in = Z0; update_data = 1'b0; en = 1'b0;
    model_clear();
    tick(); en = 1'b1;
    chk("abort_in_packet", in_packet, 1'b0);
    chk("abort_valid", bit_valid, 1'b0);
    idle(20);
    chk("abort_no_done", n_done - d0, 0);
    max_err = 3'd0;
    det0 = n_det; v0 = n_valid;
    send_word(aa, 32);
    idle(3);
    chk("redetect", n_det - det0, 1);
    send_random(PKT_BITS);
    idle(2);
    chk("valid_count_c", n_valid - v0, PKT_BITS);
    chk("done_count_c", n_done - d0, 1);

    // two bit errors, budget 1: no detection, no payload
    max_err = 3'd1;
    det0 = n_det; v0 = n_valid;
    send_word(aa_flip, 32);
    send_random(4);
    idle(3);
    chk("no_detect_err1", n_det - det0, 0);
    chk("no_valid_err1", n_valid - v0, 0);
    chk("in_packet_err1", in_packet, 1'b0);
    tick(); en = 1'b0;
    model_clear();
    tick(); en = 1'b1;
    max_err = 3'd0;

    // reset mid-payload with a coincident strobe
    send_word(aa, 32);
    send_random(50);
    idle(14);
    tick(); I_in = P7; Q_in = Z0;
    tick(); I_in = Z0; Q_in = P7; update_data = 1'b1; rst = 1'b0;
    tick(); I_in = P7; Q_in = Z0; update_data = 1'b0; rst = 1'b1;
    model_clear();
    chk("mid_rst_bit_out", bit_out, 1'b0);
    chk("mid_rst_valid", bit_valid, 1'b0);
    chk("mid_rst_detect", packet_detect, 1'b0);
    chk("mid_rst_done", packet_done, 1'b0);
    chk("mid_rst_in_packet", in_packet, 1'b0);
    idle(4);
    det0 = n_det;
    send_word(aa, 32);
    idle(3);
    chk("detect_after_rst", n_det - det0, 1);
    chk("in_packet_after_rst", in_packet, 1'b1);
    send_random(5);
    idle(4);

    chk("exp_bits_drained", exp_q.size(), 0);
    chk("exp_det_drained", det_q.size(), 0);
    chk("total_done", n_done, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
